// File: rtl/armleocpu_decode.sv
// armleocpu_decode: decode stage holding the D->E slot, issuing regfile reads and classifying instructions.
module armleocpu_decode #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int DECODE_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f2d_valid,
  input  logic [31:0]         f2d_instr,
  input  logic [31:0]         f2d_pc,
  input  logic                f2d_interrupt_pending,
  input  logic                f2d_fetch_exception,
  input  logic [31:0]         f2d_fetch_exception_cause,
  output logic                d2f_ready,
  output logic [1:0]          d2f_cmd,
  output logic [31:0]         d2f_branch_target,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic                rs1_read,
  output logic                d2e_instr_valid,
  output logic [31:0]         d2e_instr,
  output logic [31:0]         d2e_pc,
  output logic                d2e_instr_illegal,
  output logic [DECODE_W-1:0] d2e_instr_decode_type,
  output logic                d2e_interrupt_pending,
  output logic                d2e_instr_fetch_exception,
  output logic [31:0]         d2e_instr_fetch_exception_cause,
  input  logic                e2d_ready,
  input  logic [1:0]          e2d_cmd,
  input  logic [31:0]         e2d_jump_target,
  input  logic                e2d_rd_write,
  input  logic [4:0]          e2d_rd_waddr
);
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_BRANCH = 2'd1, CMD_FLUSH = 2'd2;
  localparam logic [DECODE_W-1:0] T_ALU = 0, T_JUMP = 1, T_BRANCH = 2, T_LOAD = 3, T_STORE = 4, T_SYSTEM = 5;
  typedef enum logic [1:0] {EMPTY, FULL, REREAD} state_t;
  state_t state, state_nxt;
  logic consume, jump, accept, hazard, legal;
  logic [DECODE_W-1:0] cls;
  assign consume = (state == FULL) & e2d_ready;
  assign jump = consume & (e2d_cmd == CMD_BRANCH | e2d_cmd == CMD_FLUSH);
  assign d2f_ready = rst_n & (state == EMPTY | consume) & (e2d_cmd == CMD_NONE | !consume);
  assign accept = f2d_valid & d2f_ready;
  // A same-cycle writeback to a source register means the read issued now returns stale data.
  assign hazard = e2d_rd_write & |e2d_rd_waddr &
                  (e2d_rd_waddr == f2d_instr[19:15] | e2d_rd_waddr == f2d_instr[24:20]);
  assign d2f_cmd = (rst_n & jump) ? e2d_cmd : CMD_NONE;
  assign d2f_branch_target = (rst_n & jump) ? e2d_jump_target : 32'd0;
  assign rs1_read = rst_n & (accept | state == REREAD);
  assign rs1_addr = accept ? f2d_instr[19:15] : (state != EMPTY) ? d2e_instr[19:15] : 5'd0;
  assign rs2_addr = accept ? f2d_instr[24:20] : (state != EMPTY) ? d2e_instr[24:20] : 5'd0;
  assign d2e_instr_valid = state == FULL;
  always_comb begin
    state_nxt = accept ? (hazard ? REREAD : FULL) : (state == REREAD) ? FULL : consume ? EMPTY : state;
  end
  always_comb begin
    legal = d2e_instr[1:0] == 2'b11;
    cls = T_ALU;
    case (d2e_instr[6:2])
      5'b01100, 5'b00100, 5'b01101, 5'b00101: cls = T_ALU;
      5'b11011, 5'b11001: cls = T_JUMP;
      5'b11000: cls = T_BRANCH;
      5'b00000: cls = T_LOAD;
      5'b01000: cls = T_STORE;
      5'b11100, 5'b00011: cls = T_SYSTEM;
      default: legal = 1'b0;
    endcase
  end
  assign d2e_instr_decode_type = legal ? cls : T_ALU;
  assign d2e_instr_illegal = (state != EMPTY) & !legal & !(d2e_interrupt_pending | d2e_instr_fetch_exception);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      d2e_instr <= 32'd0;
      d2e_pc <= RESET_VECTOR;
      d2e_interrupt_pending <= 1'b0;
      d2e_instr_fetch_exception <= 1'b0;
      d2e_instr_fetch_exception_cause <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        d2e_instr <= f2d_instr;
        d2e_pc <= f2d_pc;
        d2e_interrupt_pending <= f2d_interrupt_pending;
        d2e_instr_fetch_exception <= f2d_fetch_exception;
        d2e_instr_fetch_exception_cause <= f2d_fetch_exception_cause;
      end
    end
  end
endmodule

// File: tb/tb_armleocpu_decode.sv
// tb_armleocpu_decode: directed scenarios plus randomized traffic checked against a slot-level reference model.
module tb_armleocpu_decode;
  logic clk = 0, rst_n = 0;
  logic f2d_valid = 0, f2d_interrupt_pending = 0, f2d_fetch_exception = 0;
  logic [31:0] f2d_instr = 0, f2d_pc = 0, f2d_fetch_exception_cause = 0;
  logic d2f_ready, rs1_read, d2e_instr_valid, d2e_instr_illegal, d2e_interrupt_pending, d2e_instr_fetch_exception;
  logic [1:0] d2f_cmd;
  logic [31:0] d2f_branch_target, d2e_instr, d2e_pc, d2e_instr_fetch_exception_cause;
  logic [4:0] rs1_addr, rs2_addr;
  logic [2:0] d2e_instr_decode_type;
  logic e2d_ready = 0, e2d_rd_write = 0;
  logic [1:0] e2d_cmd = 0;
  logic [31:0] e2d_jump_target = 0;
  logic [4:0] e2d_rd_waddr = 0;
  int total = 0, bad = 0;
  int lut [32];
  armleocpu_decode dut (
    .clk(clk), .rst_n(rst_n), .f2d_valid(f2d_valid), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc),
    .f2d_interrupt_pending(f2d_interrupt_pending), .f2d_fetch_exception(f2d_fetch_exception),
    .f2d_fetch_exception_cause(f2d_fetch_exception_cause), .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd),
    .d2f_branch_target(d2f_branch_target), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_read(rs1_read),
    .d2e_instr_valid(d2e_instr_valid), .d2e_instr(d2e_instr), .d2e_pc(d2e_pc),
    .d2e_instr_illegal(d2e_instr_illegal), .d2e_instr_decode_type(d2e_instr_decode_type),
    .d2e_interrupt_pending(d2e_interrupt_pending), .d2e_instr_fetch_exception(d2e_instr_fetch_exception),
    .d2e_instr_fetch_exception_cause(d2e_instr_fetch_exception_cause), .e2d_ready(e2d_ready),
    .e2d_cmd(e2d_cmd), .e2d_jump_target(e2d_jump_target), .e2d_rd_write(e2d_rd_write), .e2d_rd_waddr(e2d_rd_waddr)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    f2d_valid = 0; f2d_interrupt_pending = 0; f2d_fetch_exception = 0; f2d_fetch_exception_cause = 0;
    e2d_ready = 0; e2d_cmd = 0; e2d_rd_write = 0; e2d_rd_waddr = 0; e2d_jump_target = 0;
  endtask
  task automatic do_reset;
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 13);
    return (k < 11) ? {r[31:7], ops[k]} : r;
  endfunction
  task automatic test_reset;
    rst_n = 0; f2d_valid = 1; f2d_instr = 32'h0050_0093; e2d_ready = 1; e2d_cmd = 1;
    step(); #1;
    total++; if (d2f_cmd !== 2'd0 || d2f_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd: cmd=%0d ready=%0b want 0 0", d2f_cmd, d2f_ready); end
    do_reset(); #1;
    total++; if (d2e_instr_valid !== 0 || d2e_pc !== 32'h1000 || d2e_instr !== 0 || d2e_instr_illegal !== 0 || d2e_instr_decode_type !== 0)
      begin bad++; $display("FAIL reset_slot: v=%0b pc=%h instr=%h ill=%0b type=%0d", d2e_instr_valid, d2e_pc, d2e_instr, d2e_instr_illegal, d2e_instr_decode_type); end
    total++; if (rs1_read !== 0 || rs1_addr !== 0 || rs2_addr !== 0 || d2f_cmd !== 0 || d2e_instr_fetch_exception_cause !== 0)
      begin bad++; $display("FAIL reset_out: rd=%0b a1=%0d a2=%0d cmd=%0d", rs1_read, rs1_addr, rs2_addr, d2f_cmd); end
  endtask
  task automatic test_basic;
    f2d_valid = 1; f2d_instr = 32'h0050_0093; f2d_pc = 32'h1000; #1;
    total++; if (d2f_ready !== 1 || rs1_read !== 1 || rs1_addr !== 0 || rs2_addr !== 5)
      begin bad++; $display("FAIL basic_accept: ready=%0b rd=%0b a1=%0d a2=%0d want 1 1 0 5", d2f_ready, rs1_read, rs1_addr, rs2_addr); end
    step(); f2d_valid = 0; #1;
    total++; if (d2e_instr_valid !== 1 || d2e_pc !== 32'h1000 || d2e_instr !== 32'h0050_0093 || d2e_instr_decode_type !== 0 || d2e_instr_illegal !== 0 || rs1_read !== 0)
      begin bad++; $display("FAIL basic_slot: v=%0b pc=%h instr=%h type=%0d ill=%0b rd=%0b", d2e_instr_valid, d2e_pc, d2e_instr, d2e_instr_decode_type, d2e_instr_illegal, rs1_read); end
  endtask
  task automatic test_stall;
    f2d_valid = 1; f2d_instr = 32'h0010_8093; f2d_pc = 32'h1004; e2d_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (d2f_ready !== 0 || d2e_instr_valid !== 1 || d2e_instr !== 32'h0050_0093 || d2e_pc !== 32'h1000 || rs1_read !== 0)
        begin bad++; $display("FAIL stall_%0d: ready=%0b v=%0b instr=%h pc=%h", i, d2f_ready, d2e_instr_valid, d2e_instr, d2e_pc); end
      step();
    end
  endtask
  task automatic test_branch;
    e2d_ready = 1; e2d_cmd = 1; e2d_jump_target = 32'h2000; #1;
    total++; if (d2f_cmd !== 1 || d2f_branch_target !== 32'h2000 || d2f_ready !== 0 || rs1_read !== 0)
      begin bad++; $display("FAIL branch_cmd: cmd=%0d tgt=%h ready=%0b want 1 2000 0", d2f_cmd, d2f_branch_target, d2f_ready); end
    step(); idle(); #1;
    total++; if (d2e_instr_valid !== 0 || d2f_ready !== 1 || d2f_cmd !== 0)
      begin bad++; $display("FAIL branch_empty: v=%0b ready=%0b cmd=%0d", d2e_instr_valid, d2f_ready, d2f_cmd); end
  endtask
  task automatic test_hazard;
    f2d_valid = 1; f2d_instr = 32'h0020_81b3; f2d_pc = 32'h1100; e2d_rd_write = 1; e2d_rd_waddr = 2; #1;
    total++; if (d2f_ready !== 1 || rs1_read !== 1 || rs2_addr !== 2) begin bad++; $display("FAIL hazard_accept: ready=%0b rd=%0b a2=%0d", d2f_ready, rs1_read, rs2_addr); end
    step(); idle(); f2d_valid = 1; #1;
    total++; if (d2e_instr_valid !== 0 || rs1_read !== 1 || rs1_addr !== 1 || rs2_addr !== 2 || d2f_ready !== 0)
      begin bad++; $display("FAIL hazard_bubble: v=%0b rd=%0b a1=%0d a2=%0d ready=%0b", d2e_instr_valid, rs1_read, rs1_addr, rs2_addr, d2f_ready); end
    step(); f2d_valid = 0; #1;
    total++; if (d2e_instr_valid !== 1 || rs1_read !== 0 || d2e_instr !== 32'h0020_81b3 || d2e_pc !== 32'h1100)
      begin bad++; $display("FAIL hazard_full: v=%0b rd=%0b instr=%h pc=%h", d2e_instr_valid, rs1_read, d2e_instr, d2e_pc); end
    e2d_ready = 1; step(); idle();
  endtask
  task automatic test_illegal;
    f2d_valid = 1; f2d_instr = 0; f2d_pc = 32'h3000; step();
    f2d_valid = 0; e2d_ready = 1; #1;
    total++; if (d2e_instr_valid !== 1 || d2e_instr_illegal !== 1 || d2e_instr_decode_type !== 0)
      begin bad++; $display("FAIL illegal_zero: v=%0b ill=%0b type=%0d want 1 1 0", d2e_instr_valid, d2e_instr_illegal, d2e_instr_decode_type); end
    step(); idle();
    f2d_valid = 1; f2d_fetch_exception = 1; f2d_fetch_exception_cause = 1; step();
    idle(); #1;
    total++; if (d2e_instr_valid !== 1 || d2e_instr_illegal !== 0 || d2e_instr_fetch_exception !== 1 || d2e_instr_fetch_exception_cause !== 1 || d2e_instr !== 0)
      begin bad++; $display("FAIL fetch_exc: v=%0b ill=%0b exc=%0b cause=%0d", d2e_instr_valid, d2e_instr_illegal, d2e_instr_fetch_exception, d2e_instr_fetch_exception_cause); end
    e2d_ready = 1; step(); idle();
  endtask
  task automatic test_back_to_back;
    e2d_ready = 1;
    for (int i = 0; i <= 8; i++) begin
      f2d_valid = i < 8; f2d_instr = {12'(i), 5'd1, 3'd0, 5'd1, 7'h13}; f2d_pc = 32'h4000 + 4 * i; #1;
      if (i < 8) begin
        total++; if (d2f_ready !== 1) begin bad++; $display("FAIL b2b_ready_%0d: ready=%0b want 1", i, d2f_ready); end
      end
      if (i > 0) begin
        total++; if (d2e_instr_valid !== 1 || d2e_pc !== 32'h4000 + 4 * (i - 1) || d2e_instr[31:20] !== 12'(i - 1))
          begin bad++; $display("FAIL b2b_slot_%0d: v=%0b pc=%h instr=%h", i, d2e_instr_valid, d2e_pc, d2e_instr); end
      end
      step();
    end
    idle();
  endtask
  task automatic test_random;
    logic m_valid, m_bubble, m_irq, m_exc, consume, free, ready, acc, jmp, ok, hz;
    logic [31:0] m_instr, m_pc, m_cause;
    logic [4:0] e1, e2;
    do_reset();
    m_valid = 0; m_bubble = 0; m_instr = 0; m_pc = 0; m_irq = 0; m_exc = 0; m_cause = 0;
    for (int c = 0; c < 3000; c++) begin
      f2d_valid = $urandom_range(0, 1); f2d_instr = rand_instr(); f2d_pc = $urandom;
      f2d_interrupt_pending = $urandom_range(0, 7) == 0; f2d_fetch_exception = $urandom_range(0, 7) == 0;
      f2d_fetch_exception_cause = $urandom; e2d_ready = $urandom_range(0, 1);
      e2d_cmd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      e2d_jump_target = $urandom; e2d_rd_write = $urandom_range(0, 1); e2d_rd_waddr = 5'($urandom_range(0, 7));
      #1;
      consume = m_valid & e2d_ready;
      free = (!m_valid & !m_bubble) | consume;
      ready = free & (e2d_cmd == 0 | !consume);
      acc = f2d_valid & ready;
      jmp = consume & e2d_cmd != 0;
      e1 = acc ? f2d_instr[19:15] : (m_valid | m_bubble) ? m_instr[19:15] : 5'd0;
      e2 = acc ? f2d_instr[24:20] : (m_valid | m_bubble) ? m_instr[24:20] : 5'd0;
      total++; if (d2e_instr_valid !== m_valid || d2f_ready !== ready || rs1_read !== (acc | m_bubble) || rs1_addr !== e1 || rs2_addr !== e2)
        begin bad++; $display("FAIL rnd_ctrl_%0d: v=%0b/%0b ready=%0b/%0b rd=%0b/%0b a1=%0d/%0d a2=%0d/%0d", c, d2e_instr_valid, m_valid, d2f_ready, ready, rs1_read, acc | m_bubble, rs1_addr, e1, rs2_addr, e2); end
      total++; if (d2f_cmd !== (jmp ? e2d_cmd : 2'd0) || (jmp && d2f_branch_target !== e2d_jump_target))
        begin bad++; $display("FAIL rnd_cmd_%0d: cmd=%0d tgt=%h jump=%0b", c, d2f_cmd, d2f_branch_target, jmp); end
      if (m_valid) begin
        ok = m_instr[1:0] == 2'b11 && lut[m_instr[6:2]] >= 0;
        total++; if (d2e_instr !== m_instr || d2e_pc !== m_pc || d2e_interrupt_pending !== m_irq || d2e_instr_fetch_exception !== m_exc ||
                     d2e_instr_fetch_exception_cause !== m_cause || d2e_instr_decode_type !== (ok ? 3'(lut[m_instr[6:2]]) : 3'd0) ||
                     d2e_instr_illegal !== (!ok & !m_irq & !m_exc))
          begin bad++; $display("FAIL rnd_slot_%0d: instr=%h/%h pc=%h/%h type=%0d ill=%0b", c, d2e_instr, m_instr, d2e_pc, m_pc, d2e_instr_decode_type, d2e_instr_illegal); end
      end
      hz = e2d_rd_write && e2d_rd_waddr != 0 && (e2d_rd_waddr == f2d_instr[19:15] || e2d_rd_waddr == f2d_instr[24:20]);
      if (acc) begin
        m_instr = f2d_instr; m_pc = f2d_pc; m_irq = f2d_interrupt_pending; m_exc = f2d_fetch_exception;
        m_cause = f2d_fetch_exception_cause; m_bubble = hz; m_valid = !hz;
      end else if (m_bubble) begin
        m_bubble = 0; m_valid = 1;
      end else if (consume) m_valid = 0;
      step();
    end
    idle();
  endtask
  initial begin
    foreach (lut[i]) lut[i] = -1;
    lut[5'b01100] = 0; lut[5'b00100] = 0; lut[5'b01101] = 0; lut[5'b00101] = 0;
    lut[5'b11011] = 1; lut[5'b11001] = 1; lut[5'b11000] = 2; lut[5'b00000] = 3;
    lut[5'b01000] = 4; lut[5'b11100] = 5; lut[5'b00011] = 5;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_hazard();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
